// File: rtl/fsm_alu_ctrl.sv
// Multicycle control FSM sequencing operand, ALU, regfile and PC strobes for RV32/RV64 integer ALU ops.
// Latency: start -> DECODE -> EXEC -> WB, with done 3 cycles after start; M ops add MUL_WAIT cycles until mul_done.
// Backpressure: start is only sampled in IDLE (busy=0); the external unit stalls MUL_WAIT up to MUL_TIMEOUT cycles.
//
// Ports: clk/reset (sync, active-high); start/ins request; mul_done from the external mul/div unit;
//        busy/done/illegal/err_timeout status; func3/sub_sra/word_op/mul_op ALU controls; mul_start;
//        sel_* datapath muxes; load_* register strobes.
module fsm_alu_ctrl #(
    parameter int XLEN        = 64,
    parameter int EN_WORD     = 1,
    parameter int EN_MUL      = 1,
    parameter int MUL_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] ins,
    input  logic        mul_done,
    output logic        busy,
    output logic        done,
    output logic        illegal,
    output logic        err_timeout,
    output logic [2:0]  func3,
    output logic        sub_sra,
    output logic        word_op,
    output logic        mul_op,
    output logic        mul_start,
    output logic        sel_alu_a,
    output logic        sel_alu_b,
    output logic [1:0]  sel_rd,
    output logic        sel_pc_next,
    output logic        load_rs1,
    output logic        load_rs2,
    output logic        load_alu,
    output logic        load_regfile,
    output logic        load_pc
);

    localparam bit RV64    = (XLEN == 64);
    localparam bit WORD_EN = RV64 && (EN_WORD != 0);
    localparam bit MUL_EN  = (EN_MUL != 0);
    localparam int CW      = $clog2(MUL_TIMEOUT + 1);
    // Counter holds the number of completed MUL_WAIT cycles, so the last allowed cycle sees MUL_TIMEOUT-1.
    localparam logic [CW-1:0] CNT_LAST = CW'(MUL_TIMEOUT - 1);

    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_MUL_WAIT,
        S_WB
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     ins_q, ins_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       shift_ok;
    logic       legal, is_m, r_type, i_type;

    assign opc = ins_q[6:0];
    assign f3  = ins_q[14:12];
    assign f7  = ins_q[31:25];
    // Immediate shifts allow only the plain and arithmetic funct6 patterns; ins[25] is handled per width.
    assign shift_ok = (ins_q[31:26] == 6'b000000) || (ins_q[31:26] == 6'b010000);

    // rd/rs fields and the immediate body are datapath-only; the controller never looks at them.
    logic unused_ins;
    assign unused_ins = ^{ins_q[24:15], ins_q[11:7]};

    // Decode of the latched instruction word.
    always_comb begin
        legal  = 1'b0;
        is_m   = 1'b0;
        r_type = 1'b0;
        i_type = 1'b0;
        case (opc)
            OPC_OP: begin
                r_type = 1'b1;
                case (f7)
                    7'b0000000: legal = 1'b1;
                    7'b0100000: legal = (f3 == 3'b000) || (f3 == 3'b101);
                    7'b0000001: begin
                        is_m  = 1'b1;
                        legal = MUL_EN;
                    end
                    default:    legal = 1'b0;
                endcase
            end
            OPC_OP_IMM: begin
                i_type = 1'b1;
                if ((f3 == 3'b001) || (f3 == 3'b101))
                    legal = shift_ok && (RV64 || !ins_q[25]);
                else
                    legal = 1'b1;
            end
            OPC_OP_32: begin
                r_type = 1'b1;
                case (f7)
                    7'b0000000: legal = WORD_EN && ((f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b101));
                    7'b0100000: legal = WORD_EN && ((f3 == 3'b000) || (f3 == 3'b101));
                    7'b0000001: begin
                        is_m  = 1'b1;
                        legal = WORD_EN && MUL_EN && (f3 != 3'b001) && (f3 != 3'b010) && (f3 != 3'b011);
                    end
                    default:    legal = 1'b0;
                endcase
            end
            OPC_OP_IMM_32: begin
                i_type = 1'b1;
                if (f3 == 3'b000)
                    legal = WORD_EN;
                else if ((f3 == 3'b001) || (f3 == 3'b101))
                    legal = WORD_EN && shift_ok && !ins_q[25];
                else
                    legal = 1'b0;
            end
            default: legal = 1'b0;
        endcase
    end

    // Instruction-derived controls come straight from ins_q, so they hold from DECODE through WB.
    assign func3     = f3;
    assign sel_alu_b = i_type;
    assign word_op   = (opc == OPC_OP_32) || (opc == OPC_OP_IMM_32);
    // addi with imm[10] set must not subtract, hence the func3=101 restriction for I-type.
    assign sub_sra   = ins_q[30] && ((r_type && ((f3 == 3'b000) || (f3 == 3'b101))) ||
                                     (i_type && (f3 == 3'b101)));

    assign sel_alu_a   = 1'b0;
    assign sel_rd      = 2'b00;
    assign sel_pc_next = 1'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            ins_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ins_q   <= ins_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ins_d        = ins_q;
        cnt_d        = cnt_q;
        busy         = (state_q != S_IDLE);
        done         = 1'b0;
        illegal      = 1'b0;
        err_timeout  = 1'b0;
        mul_op       = 1'b0;
        mul_start    = 1'b0;
        load_rs1     = 1'b0;
        load_rs2     = 1'b0;
        load_alu     = 1'b0;
        load_regfile = 1'b0;
        load_pc      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ins_d   = ins;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                load_rs1 = 1'b1;
                load_rs2 = 1'b1;
                state_d  = S_EXEC;
            end
            S_EXEC: begin
                if (!legal) begin
                    illegal = 1'b1;
                    state_d = S_IDLE;
                end else if (is_m) begin
                    mul_start = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_MUL_WAIT;
                end else begin
                    load_alu = 1'b1;
                    state_d  = S_WB;
                end
            end
            S_MUL_WAIT: begin
                mul_op = 1'b1;
                cnt_d  = cnt_q + CW'(1);
                // A result arriving in the final allowed cycle still wins over the abort.
                if (mul_done) begin
                    load_alu = 1'b1;
                    state_d  = S_WB;
                end else if (cnt_q == CNT_LAST) begin
                    err_timeout = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            S_WB: begin
                load_regfile = 1'b1;
                load_pc      = 1'b1;
                done         = 1'b1;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_fsm_alu_ctrl.sv
// Bench for fsm_alu_ctrl: an RV64 M-capable instance (timeout 8) and an RV32 instance without M share stimulus.
// Completion events (done/illegal/err_timeout) are checked against a per-instance expectation queue.
module tb_fsm_alu_ctrl;

    localparam logic [31:0] I_ADD   = 32'h001102B3;
    localparam logic [31:0] I_ADDI  = 32'h00A08313;
    localparam logic [31:0] I_ADDI2 = 32'h40008313;
    localparam logic [31:0] I_SUB   = 32'h401103B3;
    localparam logic [31:0] I_SRAI  = 32'h405A5513;
    localparam logic [31:0] I_MUL   = 32'h021102B3;
    localparam logic [31:0] I_ADDW  = 32'h001102BB;
    localparam logic [31:0] I_SLLI  = 32'h02009293;

    localparam int K_DONE = 1, K_ILL = 2, K_TMO = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, mul_done;
    logic [31:0] ins;
    logic [1:0]  busy, done, illegal, err_timeout, sub_sra, word_op, mul_op, mul_start;
    logic [1:0]  sel_alu_a, sel_alu_b, sel_pc_next, load_rs1, load_rs2, load_alu, load_regfile, load_pc;
    logic [2:0]  func3 [2];
    logic [1:0]  sel_rd [2];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int         kind;
        int         cyc;
        logic [2:0] f3;
        logic       sub;
        logic       selb;
        logic       word;
    } exp_t;

    exp_t sbq0[$];
    exp_t sbq1[$];

    fsm_alu_ctrl #(.XLEN(64), .EN_WORD(1), .EN_MUL(1), .MUL_TIMEOUT(8)) u_dut64 (
        .clk(clk), .reset(reset), .start(start), .ins(ins), .mul_done(mul_done),
        .busy(busy[0]), .done(done[0]), .illegal(illegal[0]), .err_timeout(err_timeout[0]),
        .func3(func3[0]), .sub_sra(sub_sra[0]), .word_op(word_op[0]), .mul_op(mul_op[0]),
        .mul_start(mul_start[0]), .sel_alu_a(sel_alu_a[0]), .sel_alu_b(sel_alu_b[0]),
        .sel_rd(sel_rd[0]), .sel_pc_next(sel_pc_next[0]), .load_rs1(load_rs1[0]),
        .load_rs2(load_rs2[0]), .load_alu(load_alu[0]), .load_regfile(load_regfile[0]),
        .load_pc(load_pc[0])
    );

    fsm_alu_ctrl #(.XLEN(32), .EN_WORD(1), .EN_MUL(0), .MUL_TIMEOUT(8)) u_dut32 (
        .clk(clk), .reset(reset), .start(start), .ins(ins), .mul_done(mul_done),
        .busy(busy[1]), .done(done[1]), .illegal(illegal[1]), .err_timeout(err_timeout[1]),
        .func3(func3[1]), .sub_sra(sub_sra[1]), .word_op(word_op[1]), .mul_op(mul_op[1]),
        .mul_start(mul_start[1]), .sel_alu_a(sel_alu_a[1]), .sel_alu_b(sel_alu_b[1]),
        .sel_rd(sel_rd[1]), .sel_pc_next(sel_pc_next[1]), .load_rs1(load_rs1[1]),
        .load_rs2(load_rs2[1]), .load_alu(load_alu[1]), .load_regfile(load_regfile[1]),
        .load_pc(load_pc[1])
    );

    // Strobe vector: busy rs1 rs2 alu rf pc done mstart mop ill tmo
    function automatic logic [10:0] st(input int d);
        return {busy[d], load_rs1[d], load_rs2[d], load_alu[d], load_regfile[d], load_pc[d],
                done[d], mul_start[d], mul_op[d], illegal[d], err_timeout[d]};
    endfunction

    function automatic logic [20:0] allout(input int d);
        return {st(d), func3[d], sub_sra[d], word_op[d], sel_alu_a[d], sel_alu_b[d],
                sel_rd[d], sel_pc_next[d]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int d, input int kind, input int c, input logic [2:0] f3,
                        input logic sub, input logic selb, input logic word);
        exp_t e;
        e.kind = kind; e.cyc = c; e.f3 = f3; e.sub = sub; e.selb = selb; e.word = word;
        if (d == 0) sbq0.push_back(e);
        else        sbq1.push_back(e);
    endtask

    // Scoreboard: every completion pulse pops the oldest expectation for that instance.
    exp_t e_m;
    int   obs_kind;
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (done[d] || illegal[d] || err_timeout[d]) begin
                obs_kind = done[d] ? K_DONE : (illegal[d] ? K_ILL : K_TMO);
                n_cmp++;
                if ((d == 0 && sbq0.size() == 0) || (d == 1 && sbq1.size() == 0)) begin
                    n_err++;
                    $display("FAIL unexpected_completion dut%0d: got kind %0d at cycle %0d, want none",
                             d, obs_kind, cyc);
                end else begin
                    if (d == 0) e_m = sbq0.pop_front();
                    else        e_m = sbq1.pop_front();
                    if (obs_kind != e_m.kind || cyc != e_m.cyc) begin
                        n_err++;
                        $display("FAIL completion dut%0d: got kind %0d at cycle %0d, want kind %0d at cycle %0d",
                                 d, obs_kind, cyc, e_m.kind, e_m.cyc);
                    end
                    if (e_m.kind == K_DONE) begin
                        n_cmp++;
                        if ({func3[d], sub_sra[d], sel_alu_b[d], word_op[d]} !==
                            {e_m.f3, e_m.sub, e_m.selb, e_m.word}) begin
                            n_err++;
                            $display("FAIL wb_controls dut%0d: got f3/sub/selb/word %b, want %b", d,
                                     {func3[d], sub_sra[d], sel_alu_b[d], word_op[d]},
                                     {e_m.f3, e_m.sub, e_m.selb, e_m.word});
                        end
                    end
                end
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; mul_done = 1'b0; ins = '0;
        step(); step();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (allout(d) !== 21'd0) begin
                n_err++;
                $display("FAIL reset_outputs dut%0d: got %b, want 0", d, allout(d));
            end
        end
        step();
        reset = 1'b0;
        step();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (allout(d) !== 21'd0) begin
                n_err++;
                $display("FAIL idle_after_reset dut%0d: got %b, want 0", d, allout(d));
            end
        end
        step();
    endtask

    task automatic test_add();
        logic [10:0] ex [5];
        int t0;
        ex = '{11'b0, 11'b11100000000, 11'b10010000000, 11'b10001110000, 11'b0};
        t0 = cyc;
        ins = I_ADD; start = 1'b1;
        for (int d = 0; d < 2; d++) push(d, K_DONE, t0 + 3, 3'b000, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                n_cmp++;
                if (st(d) !== ex[k]) begin
                    n_err++;
                    $display("FAIL add_strobes dut%0d cycle %0d: got %b, want %b", d, k, st(d), ex[k]);
                end
                if (k == 2) begin
                    n_cmp++;
                    if ({func3[d], sub_sra[d], sel_alu_b[d]} !== 5'b00000) begin
                        n_err++;
                        $display("FAIL add_exec_ctrl dut%0d: got %b, want 00000", d,
                                 {func3[d], sub_sra[d], sel_alu_b[d]});
                    end
                end
            end
            step();
            if (k == 0) start = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        int t0;
        t0 = cyc;
        ins = I_ADDI; start = 1'b1;
        for (int d = 0; d < 2; d++) begin
            push(d, K_DONE, t0 + 3, 3'b000, 1'b0, 1'b1, 1'b0);
            push(d, K_DONE, t0 + 7, 3'b000, 1'b0, 1'b1, 1'b0);
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (k == 2) begin
                    n_cmp++;
                    if ({func3[d], sub_sra[d], sel_alu_b[d]} !== 5'b00001) begin
                        n_err++;
                        $display("FAIL addi_stable dut%0d: got %b, want 00001", d,
                                 {func3[d], sub_sra[d], sel_alu_b[d]});
                    end
                end
                if (k == 4 || k == 5) begin
                    n_cmp++;
                    if (busy[d] !== (k == 5)) begin
                        n_err++;
                        $display("FAIL b2b_busy dut%0d cycle %0d: got %b, want %b", d, k, busy[d], k == 5);
                    end
                end
            end
            step();
            if (k == 0) ins = 32'hFFFF_FFFF;
            if (k == 3) ins = I_ADDI2;
            if (k == 4) start = 1'b0;
        end
    endtask

    task automatic test_sub_srai();
        int t0;
        t0 = cyc;
        ins = I_SUB; start = 1'b1;
        for (int d = 0; d < 2; d++) begin
            push(d, K_DONE, t0 + 3, 3'b000, 1'b1, 1'b0, 1'b0);
            push(d, K_DONE, t0 + 7, 3'b101, 1'b1, 1'b1, 1'b0);
        end
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            if (k == 5) begin
                for (int d = 0; d < 2; d++) begin
                    n_cmp++;
                    if ({func3[d], sub_sra[d], sel_alu_b[d]} !== 5'b10111) begin
                        n_err++;
                        $display("FAIL srai_decode dut%0d: got %b, want 10111", d,
                                 {func3[d], sub_sra[d], sel_alu_b[d]});
                    end
                end
            end
            step();
            if (k == 0) start = 1'b0;
            if (k == 3) begin ins = I_SRAI; start = 1'b1; end
            if (k == 4) start = 1'b0;
        end
    endtask

    task automatic test_mul();
        logic [10:0] ex [2][7];
        int t0;
        ex = '{'{11'b0, 11'b11100000000, 11'b10000001000, 11'b10000000100,
                 11'b10000000100, 11'b10010000100, 11'b10001110000},
               '{11'b0, 11'b11100000000, 11'b10000000010, 11'b0, 11'b0, 11'b0, 11'b0}};
        t0 = cyc;
        ins = I_MUL; start = 1'b1;
        push(0, K_DONE, t0 + 6, 3'b000, 1'b0, 1'b0, 1'b0);
        push(1, K_ILL, t0 + 2, 3'b000, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                n_cmp++;
                if (st(d) !== ex[d][k]) begin
                    n_err++;
                    $display("FAIL mul_strobes dut%0d cycle %0d: got %b, want %b", d, k, st(d), ex[d][k]);
                end
            end
            step();
            if (k == 0) start = 1'b0;
            if (k == 1 || k == 4) mul_done = 1'b1;
            if (k == 2 || k == 5) mul_done = 1'b0;
        end
    endtask

    task automatic test_word();
        int t0;
        t0 = cyc;
        ins = I_ADDW; start = 1'b1;
        push(0, K_DONE, t0 + 3, 3'b000, 1'b0, 1'b0, 1'b1);
        push(1, K_ILL,  t0 + 2, 3'b000, 1'b0, 1'b0, 1'b0);
        push(0, K_DONE, t0 + 7, 3'b001, 1'b0, 1'b1, 1'b0);
        push(1, K_ILL,  t0 + 6, 3'b000, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            if (k == 2) begin
                n_cmp++;
                if (word_op[0] !== 1'b1 || load_alu[0] !== 1'b1) begin
                    n_err++;
                    $display("FAIL addw_exec dut0: got word_op/load_alu %b%b, want 11", word_op[0], load_alu[0]);
                end
            end
            step();
            if (k == 0) start = 1'b0;
            if (k == 3) begin ins = I_SLLI; start = 1'b1; end
            if (k == 4) start = 1'b0;
        end
    endtask

    task automatic test_timeout();
        int t0;
        t0 = cyc;
        ins = I_MUL; start = 1'b1;
        push(0, K_TMO, t0 + 10, 3'b000, 1'b0, 1'b0, 1'b0);
        push(1, K_ILL, t0 + 2, 3'b000, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 9 || k == 11) begin
                n_cmp++;
                if (busy[0] !== (k == 9)) begin
                    n_err++;
                    $display("FAIL timeout_busy dut0 cycle %0d: got %b, want %b", k, busy[0], k == 9);
                end
            end
            step();
            if (k == 0) start = 1'b0;
        end
    endtask

    task automatic test_reset_abort();
        int t0;
        t0 = cyc;
        ins = I_MUL; start = 1'b1;
        push(1, K_ILL, t0 + 2, 3'b000, 1'b0, 1'b0, 1'b0);
        for (int d = 0; d < 2; d++) push(d, K_DONE, t0 + 12, 3'b000, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (k >= 6 && k <= 8) begin
                    n_cmp++;
                    if (allout(d) !== 21'd0) begin
                        n_err++;
                        $display("FAIL abort_outputs dut%0d cycle %0d: got %b, want 0", d, k, allout(d));
                    end
                end
                if (k == 13) begin
                    n_cmp++;
                    if (busy[d] !== 1'b0) begin
                        n_err++;
                        $display("FAIL restart_idle dut%0d: got busy %b, want 0", d, busy[d]);
                    end
                end
            end
            step();
            if (k == 0) start = 1'b0;
            if (k == 4) reset = 1'b1;
            if (k == 5) reset = 1'b0;
            if (k == 6) mul_done = 1'b1;
            if (k == 8) begin mul_done = 1'b0; ins = I_ADD; start = 1'b1; end
            if (k == 9) start = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; mul_done = 1'b0; ins = '0;
        test_reset();
        test_add();
        test_back_to_back();
        test_sub_srai();
        test_mul();
        test_word();
        test_timeout();
        test_reset_abort();
        step(); step();
        n_cmp++;
        if (sbq0.size() + sbq1.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sbq0.size() + sbq1.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
